// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the four-digit seven-segment scan controller.
// Optional blink support is built when SSD_BLINK_EN is defined.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef logic [1:0] slot_t;

  function automatic logic [3:0] nib_sel(
    input logic [15:0] v,
    input slot_t s
  );
    return v[{s, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] an_sel(
    input slot_t s
  );
    return ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/ssd_refresh_timer.sv
// Slot prescaler and digit index for the scan controller.
// Under SSD_BLINK_EN it also keeps an 8-bit frame counter for blink phase.
module ssd_refresh_timer
  import sevenseg_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GUARD = 2
) (
  input  logic  Clk,
  input  logic  Reset,
  output logic  tick,
  output logic  frame_end,
  output slot_t idx,
  output logic  guard_active,
  output logic  blink_phase
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);
  assign frame_end = tick && (idx == 2'd3);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // GUARD of zero means anodes may light from the first cycle of a slot
  generate
    if (GUARD == 0) begin : g_noguard
      assign guard_active = 1'b0;
    end else begin : g_guard
      assign guard_active = (cnt < CW'(GUARD));
    end
  endgenerate

`ifdef SSD_BLINK_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign blink_phase = frame_cnt[7];
`else
  assign blink_phase = 1'b0;
`endif

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with frame-aligned load commit.
// Define SSD_BLINK_EN to add the BlinkIn port and per-digit blinking.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int GUARD = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] DigitsIn,
  input  logic [3:0]  BlankIn,
`ifdef SSD_BLINK_EN
  input  logic [3:0]  BlinkIn,
`endif
  input  logic        Load,
  output logic        LoadAck,
  output logic [3:0]  Dig,
  output logic [3:0]  An
);

  logic  tick_unused;
  logic  frame_end;
  slot_t idx;
  logic  guard_active;
  logic  blink_phase;

  ssd_refresh_timer #(
    .CLK_DIV(CLK_DIV),
    .GUARD  (GUARD)
  ) u_timer (
    .Clk         (Clk),
    .Reset       (Reset),
    .tick        (tick_unused),
    .frame_end   (frame_end),
    .idx         (idx),
    .guard_active(guard_active),
    .blink_phase (blink_phase)
  );

  logic [15:0] act_dig;
  logic [3:0]  act_blank;
  logic [15:0] sh_dig;
  logic [3:0]  sh_blank;
  logic        pend;
  logic        commit;
  logic        lit;

  assign commit = frame_end && pend;

`ifdef SSD_BLINK_EN
  logic [3:0] act_blink;
  logic [3:0] sh_blink;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      act_blink <= '0;
      sh_blink <= '0;
    end else begin
      if (commit) act_blink <= sh_blink;
      if (Load) sh_blink <= BlinkIn;
    end
  end

  assign lit = !guard_active && !act_blank[idx]
            && !(blink_phase && act_blink[idx]);
`else
  logic blink_unused;
  assign blink_unused = blink_phase;
  assign lit = !guard_active && !act_blank[idx];
`endif

  // Commit reads the old shadow before a same-cycle Load refills it
  always_ff @(posedge Clk) begin
    if (Reset) begin
      act_dig <= '0;
      act_blank <= AN_OFF;
      sh_dig <= '0;
      sh_blank <= AN_OFF;
      pend <= 1'b0;
      LoadAck <= 1'b0;
    end else begin
      LoadAck <= commit;
      if (commit) begin
        act_dig <= sh_dig;
        act_blank <= sh_blank;
        pend <= 1'b0;
      end
      if (Load) begin
        sh_dig <= DigitsIn;
        sh_blank <= BlankIn;
        pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Dig <= 4'h0;
      An <= AN_OFF;
    end else begin
      Dig <= nib_sel(act_dig, idx);
      An <= lit ? an_sel(idx) : AN_OFF;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl against a cycle-count model.
// Honours SSD_BLINK_EN when defined.
module tb_sevenseg_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int GUARD = 1;
  localparam int FRAME = 4 * CLK_DIV;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] DigitsIn = '0;
  logic [3:0]  BlankIn = '0;
  logic [3:0]  BlinkIn = '0;
  logic        Load = 1'b0;
  logic        LoadAck;
  logic [3:0]  Dig;
  logic [3:0]  An;

  sevenseg_scan_ctrl #(
    .CLK_DIV(CLK_DIV),
    .GUARD  (GUARD)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .DigitsIn(DigitsIn),
    .BlankIn (BlankIn),
`ifdef SSD_BLINK_EN
    .BlinkIn (BlinkIn),
`endif
    .Load    (Load),
    .LoadAck (LoadAck),
    .Dig     (Dig),
    .An      (An)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: elapsed cycles since reset give the slot position directly
  int          t;
  logic [15:0] m_act, m_sh;
  logic [3:0]  m_ablank, m_sblank;
  logic [3:0]  m_ablink, m_sblink;
  int          m_frames;
  bit          m_pend;
  logic        m_ack;
  logic [3:0]  m_dig, m_an;
  int          acks;
  logic        prev_ack;

  task automatic model_edge();
    int  c;
    int  s;
    bit  bnd;
    bit  on;
    if (Reset) begin
      t = 0;
      m_act = '0;
      m_sh = '0;
      m_ablank = 4'hF;
      m_sblank = 4'hF;
      m_ablink = '0;
      m_sblink = '0;
      m_frames = 0;
      m_pend = 0;
      m_ack = 0;
      m_dig = '0;
      m_an = 4'hF;
    end else begin
      c = t % CLK_DIV;
      s = (t / CLK_DIV) % 4;
      bnd = (t % FRAME) == FRAME - 1;
      on = (c >= GUARD) && !m_ablank[s];
`ifdef SSD_BLINK_EN
      if (((m_frames / 128) % 2) == 1 && m_ablink[s]) on = 0;
`endif
      m_dig = m_act[4*s +: 4];
      m_an = 4'hF;
      if (on) m_an[s] = 1'b0;
      m_ack = bnd && m_pend;
      if (bnd) m_frames++;
      if (m_ack) begin
        m_act = m_sh;
        m_ablank = m_sblank;
        m_ablink = m_sblink;
        m_pend = 0;
      end
      if (Load) begin
        m_sh = DigitsIn;
        m_sblank = BlankIn;
        m_sblink = BlinkIn;
        m_pend = 1;
      end
      t++;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    chk("dig", {12'h0, Dig}, {12'h0, m_dig});
    chk("an", {12'h0, An}, {12'h0, m_an});
    chk("ack", {15'h0, LoadAck}, {15'h0, m_ack});
    chk("ack_twice", {15'h0, prev_ack && LoadAck}, 16'h0);
    if (LoadAck) acks++;
    prev_ack = LoadAck;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to(input int ph);
    repeat (FRAME) if ((t % FRAME) != ph) step();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Load = 1'b0;
    run(2);
    Reset = 1'b0;
    acks = 0;
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] b);
    DigitsIn = d;
    BlankIn = b;
    Load = 1'b1;
    step();
    Load = 1'b0;
  endtask

  initial begin
    prev_ack = 1'b0;
    acks = 0;
    t = 0;

    do_reset();
    run(20);
    chk("idle_acks", 16'(acks), 16'd0);

    do_reset();
    run(2);
    load(16'h4321, 4'b0000);
    run(3 * FRAME);
    chk("4321_acks", 16'(acks), 16'd1);

    do_reset();
    run_to(0);
    load(16'h1111, 4'b0000);
    step();
    load(16'h9999, 4'b0000);
    run(2 * FRAME);
    chk("overwrite_acks", 16'(acks), 16'd1);

    do_reset();
    run(2);
    load(16'h2468, 4'b0000);
    run_to(FRAME - 1);
    load(16'h1357, 4'b0010);
    run(2 * FRAME);
    chk("bnd_load_acks", 16'(acks), 16'd2);

    do_reset();
    load(16'h5555, 4'b0100);
    run(3 * FRAME);
    chk("blank_acks", 16'(acks), 16'd1);

    do_reset();
    run(3);
    load(16'h7777, 4'b0000);
    run(4);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    acks = 0;
    run(2 * FRAME);
    chk("rst_pend_acks", 16'(acks), 16'd0);

    for (int i = 0; i < 1500; i++) begin
      DigitsIn = 16'($urandom);
      BlankIn = 4'($urandom);
      BlinkIn = 4'($urandom);
      Load = ($urandom_range(0, 7) == 0);
      Reset = ($urandom_range(0, 399) == 0);
      step();
    end
    Reset = 1'b0;
    Load = 1'b0;

`ifdef SSD_BLINK_EN
    do_reset();
    BlinkIn = 4'b0101;
    load(16'h8642, 4'b0000);
    run(140 * FRAME);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
